// File: rtl/pipelined_adder_nbit.sv
// -----------------------------------------------------------------------------
// pipelined_adder_nbit
//   WIDTH-bit adder with carry-in, split into STAGES slices of WIDTH/STAGES bits.
//   Each slice is a ripple chain built from pairs of half adders. The carry out
//   of a slice is registered and consumed by the next slice one cycle later.
//   Operand bits not yet consumed travel down the pipe with the partial sum.
//
//   Handshake: in_valid/in_ready on the input side, out_valid/out_ready on the
//   output side. One global stall (out_valid & ~out_ready) freezes every
//   pipeline register, so in_ready is combinational from out_ready.
//
//   Optional feature macro: ADDER_OVF_EN
//     defined   -> Ovf port present: signed overflow, registered with Sum.
//     undefined -> no Ovf port and no overflow logic.
// -----------------------------------------------------------------------------
module pipelined_adder_nbit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
`ifdef ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    // Bits handled by each slice.
    localparam int SW = WIDTH / STAGES;

    genvar gi;
    genvar gj;

    // Reject configurations that cannot be split into equal slices.
    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder_nbit: WIDTH must be >= 1 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Global flow control: the whole pipe either advances or holds.
    logic stall;
    logic advance;

    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    // -------------------------------------------------------------------------
    // Pipeline stages. Stage gi computes slice gi combinationally from the
    // operands it receives and registers the result at its output.
    //   IN_W  : operand bits still to be consumed when entering this stage
    //   OUT_W : low sum bits known after this stage
    //   REM_W : operand bits forwarded to later stages
    // -------------------------------------------------------------------------
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int IN_W  = WIDTH - gi * SW;
        localparam int OUT_W = (gi + 1) * SW;
        localparam int REM_W = WIDTH - OUT_W;

        logic [IN_W-1:0]  a_in;
        logic [IN_W-1:0]  b_in;
        logic             c_in;
        logic             v_in;
        logic [SW:0]      chain;
        logic [SW-1:0]    slice_sum;
        logic [OUT_W-1:0] sum_next;

        logic             valid_reg;
        logic             carry_reg;
        logic [OUT_W-1:0] sum_reg;

        // Stage inputs: primary ports for the first slice, previous stage
        // registers for all others.
        if (gi == 0) begin : g_src
            assign a_in     = A;
            assign b_in     = B;
            assign c_in     = Cin;
            assign v_in     = in_valid;
            assign sum_next = slice_sum;
        end else begin : g_src
            assign a_in     = g_stage[gi-1].g_fwd.a_reg;
            assign b_in     = g_stage[gi-1].g_fwd.b_reg;
            assign c_in     = g_stage[gi-1].carry_reg;
            assign v_in     = g_stage[gi-1].valid_reg;
            assign sum_next = {slice_sum, g_stage[gi-1].sum_reg};
        end

        // Ripple chain: each bit is two half adders plus an OR for carry-out.
        assign chain[0] = c_in;
        for (gj = 0; gj < SW; gj++) begin : g_bit
            logic ha0_s;
            logic ha0_c;
            logic ha1_s;
            logic ha1_c;

            assign ha0_s          = a_in[gj] ^ b_in[gj];
            assign ha0_c          = a_in[gj] & b_in[gj];
            assign ha1_s          = ha0_s ^ chain[gj];
            assign ha1_c          = ha0_s & chain[gj];
            assign slice_sum[gj]  = ha1_s;
            assign chain[gj+1]    = ha0_c | ha1_c;
        end

        // Stage valid always follows its source when the pipe moves; data only
        // loads on a valid beat so the output holds its last value across bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                sum_reg   <= '0;
            end else if (advance) begin
                valid_reg <= v_in;
                if (v_in) begin
                    carry_reg <= chain[SW];
                    sum_reg   <= sum_next;
                end
            end
        end

        // Upper operand bits that later slices still need.
        if (REM_W > 0) begin : g_fwd
            logic [REM_W-1:0] a_reg;
            logic [REM_W-1:0] b_reg;

            // Forward unconsumed operand slices unchanged alongside the sum.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (advance && v_in) begin
                    a_reg <= a_in[IN_W-1:SW];
                    b_reg <= b_in[IN_W-1:SW];
                end
            end
        end
    end

    // Result comes straight from the last stage's registers.
    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign Sum       = g_stage[STAGES-1].sum_reg;
    assign Carry     = g_stage[STAGES-1].carry_reg;

`ifdef ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of the MSB.
    logic ovf_next;
    logic ovf_reg;

    assign ovf_next = g_stage[STAGES-1].chain[SW-1] ^ g_stage[STAGES-1].chain[SW];

    // Overflow flag registered in lockstep with the last stage's sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (advance && g_stage[STAGES-1].v_in) begin
            ovf_reg <= ovf_next;
        end
    end

    assign Ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder_nbit
//   Directed vector table on the default 8-bit / 2-stage instance, hand-written
//   stall and reset sequences, and short random scoreboard runs on a 16/4 and
//   a 3/1 instance. Ovf checks are compiled only when ADDER_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipelined_adder_nbit;

    logic clk;
    logic rst;

    // 8-bit / 2-stage instance
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carry;
`ifdef ADDER_OVF_EN
    logic       ovf;
`endif

    // 16-bit / 4-stage instance
    logic        v16;
    logic        rdy16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        c16;
    logic        ov16;
    logic        r16;
    logic [15:0] s16;
    logic        co16;
`ifdef ADDER_OVF_EN
    logic        ovf16;
`endif

    // 3-bit / 1-stage instance
    logic       v3;
    logic       rdy3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       c3;
    logic       ov3;
    logic       r3;
    logic [2:0] s3;
    logic       co3;
`ifdef ADDER_OVF_EN
    logic       ovf3;
`endif

    int tests;
    int failures;

    pipelined_adder_nbit #(.WIDTH(8), .STAGES(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(sum), .Carry(carry)
`ifdef ADDER_OVF_EN
        , .Ovf(ovf)
`endif
    );

    pipelined_adder_nbit #(.WIDTH(16), .STAGES(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
        .A(a16), .B(b16), .Cin(c16), .out_valid(ov16), .out_ready(r16),
        .Sum(s16), .Carry(co16)
`ifdef ADDER_OVF_EN
        , .Ovf(ovf16)
`endif
    );

    pipelined_adder_nbit #(.WIDTH(3), .STAGES(1)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
        .A(a3), .B(b3), .Cin(c3), .out_valid(ov3), .out_ready(r3),
        .Sum(s3), .Carry(co3)
`ifdef ADDER_OVF_EN
        , .Ovf(ovf3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    // Random traffic on the 16/4 instance against an A+B+Cin scoreboard.
    task automatic run_random16(input int n);
        logic [16:0] exp_q[$];
        logic [16:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v16 = ($urandom_range(0, 3) != 0);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom_range(0, 1));
            r16 = ($urandom_range(0, 3) != 0);
            #1;
            if (v16 && rdy16) exp_q.push_back({1'b0, a16} + {1'b0, b16} + 17'(c16));
            if (ov16 && r16) begin
                if (exp_q.size() == 0) begin
                    check("r16_spurious_output", 32'(s16), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("r16_sum", 32'({co16, s16}), 32'(e));
                end
            end
        end
        @(negedge clk);
        v16 = 1'b0;
        r16 = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            #1;
            if (ov16) begin
                e = exp_q.pop_front();
                check("r16_drain_sum", 32'({co16, s16}), 32'(e));
            end
            @(negedge clk);
        end
        check("r16_items_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] random 16/4: %0d cycles done", n);
    endtask

    // Random traffic on the 3/1 instance against an A+B+Cin scoreboard.
    task automatic run_random3(input int n);
        logic [3:0] exp_q[$];
        logic [3:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v3 = ($urandom_range(0, 3) != 0);
            a3 = 3'($urandom);
            b3 = 3'($urandom);
            c3 = 1'($urandom_range(0, 1));
            r3 = ($urandom_range(0, 3) != 0);
            #1;
            if (v3 && rdy3) exp_q.push_back({1'b0, a3} + {1'b0, b3} + 4'(c3));
            if (ov3 && r3) begin
                if (exp_q.size() == 0) begin
                    check("r3_spurious_output", 32'(s3), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("r3_sum", 32'({co3, s3}), 32'(e));
                end
            end
        end
        @(negedge clk);
        v3 = 1'b0;
        r3 = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            #1;
            if (ov3) begin
                e = exp_q.pop_front();
                check("r3_drain_sum", 32'({co3, s3}), 32'(e));
            end
            @(negedge clk);
        end
        check("r3_items_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] random 3/1: %0d cycles done", n);
    endtask

    initial begin
        tests    = 0;
        failures = 0;

        //           a      b      cin   sum    carry ovf
        vecs[0] = '{8'h0A, 8'h0B, 1'b1, 8'h16, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h05, 8'hFB, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0; r16 = 1'b1;
        v3  = 1'b0; a3  = '0; b3  = '0; c3  = 1'b0; r3  = 1'b1;

        // Reset state (asynchronous assertion, no clock edge needed)
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef ADDER_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: one at a time, latency exactly 2
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("vec_not_early", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_sum", 32'(sum), 32'(vecs[i].sum));
            check("vec_carry", 32'(carry), 32'(vecs[i].carry));
`ifdef ADDER_OVF_EN
            check("vec_ovf", 32'(ovf), 32'(vecs[i].ovf));
`endif
            $display("[TB] vec %0d: %h + %h + %0d -> sum %h carry %0d", i, vecs[i].a, vecs[i].b,
                     vecs[i].cin, sum, carry);
        end

        // Back-to-back stream then a 3-cycle stall with one more item in flight
        @(negedge clk);
        cin = 1'b0; a = 8'd1; b = 8'd1; in_valid = 1'b1;
        @(negedge clk);
        a = 8'd2; b = 8'd2;
        @(negedge clk);
        a = 8'd3; b = 8'd3;
        check("b2b_first_valid", 32'(out_valid), 32'd1);
        check("b2b_first_sum", 32'(sum), 32'd2);
        @(negedge clk);
        a = 8'd4; b = 8'd4;
        check("b2b_second_sum", 32'(sum), 32'd4);
        @(negedge clk);
        check("b2b_third_sum", 32'(sum), 32'd6);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h55; b = 8'h55;
        #1;
        check("stall_in_ready_comb", 32'(in_ready), 32'd0);
        $display("[TB] stream 1+1,2+2,3+3,4+4 issued; stalling output");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid_held", 32'(out_valid), 32'd1);
            check("stall_sum_held", 32'(sum), 32'd6);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("after_stall_valid", 32'(out_valid), 32'd1);
        check("after_stall_sum", 32'(sum), 32'd8);
        @(negedge clk);
        check("after_stall_empty", 32'(out_valid), 32'd0);

        // Reset with two results in flight
        @(negedge clk);
        a = 8'h10; b = 8'h20; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h30; b = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        check("preflush_sum", 32'(sum), 32'h30);
        #2 rst = 1'b1;
        #1;
        check("flush_valid_async", 32'(out_valid), 32'd0);
        check("flush_sum", 32'(sum), 32'd0);
        check("flush_carry", 32'(carry), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_nothing_emitted", 32'(out_valid), 32'd0);
        end
        a = 8'h21; b = 8'h21; cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_flush_valid", 32'(out_valid), 32'd1);
        check("post_flush_sum", 32'(sum), 32'h43);
        $display("[TB] flush: 0x21+0x21+1 -> sum %h", sum);

        run_random16(400);
        run_random3(400);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
